// File: rtl/std_reg_pkg.sv
// Shared helpers for the std_reg_bank register bank: lane arithmetic,
// lane-mask expansion and a parameter sanity check used at elaboration.
package std_reg_pkg;

    // Widest data word the mask helper supports; wider banks fail the param check.
    localparam int MASK_MAX = 1024;
    localparam int MASK_AW  = 10;

    // Number of write-mask lanes in a word.
    function automatic int lane_count(input int width, input int lane_w);
        return width / lane_w;
    endfunction

    // Expand a per-lane mask into a per-bit mask (lane i covers bits i*lane_w +: lane_w).
    function automatic logic [MASK_MAX-1:0] expand_mask(input logic [MASK_MAX-1:0] mask,
                                                        input int lane_w);
        logic [MASK_MAX-1:0] bits;
        bits = '0;
        for (int i = 0; i < MASK_MAX; i++) begin
            bits[MASK_AW'(i)] = mask[MASK_AW'(i / lane_w)];
        end
        return bits;
    endfunction

    // Legal geometry: whole lanes only, at least two entries, within helper range.
    function automatic bit params_ok(input int width, input int lane_w, input int depth);
        return (lane_w > 0) && (width > 0) && (width % lane_w == 0) &&
               (depth >= 2) && (width <= MASK_MAX);
    endfunction

endpackage

// File: rtl/std_reg_entry.sv
// One entry of std_reg_bank: a lane-masked data register plus its valid bit.
// reset and clear both zero the data and drop valid; clear is the functional flush.
module std_reg_entry
    import std_reg_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LANE_W = 8,
    localparam int LANES = lane_count(WIDTH, LANE_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             we,
    input  logic [LANES-1:0] wmask,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [WIDTH-1:0] mask_bits;

    assign mask_bits = WIDTH'(expand_mask(MASK_MAX'(wmask), LANE_W));

    // Masked lanes take the new data; a write always marks the entry valid, even with an empty mask.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (we) begin
            q     <= (q & ~mask_bits) | (in & mask_bits);
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/std_reg_bank.sv
// std_reg_bank: DEPTH x WIDTH register bank, one lane-masked write port,
// two combinational read ports, per-entry valid bits and a one-cycle done pulse
// after every accepted write.
// Optional feature macro STD_REG_BANK_BYPASS_EN: forwards a same-cycle accepted
// write to a read port addressing the written entry (merged by lane mask).
module std_reg_bank
    import std_reg_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 4,
    localparam int LANES = lane_count(WIDTH, LANE_W),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic [AW-1:0]    waddr,
    input  logic [LANES-1:0] wmask,
    input  logic [WIDTH-1:0] in,
    input  logic             clear,
    input  logic [AW-1:0]    raddr0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic             out0_valid,
    output logic             out1_valid,
    output logic             done
);

    if (!params_ok(WIDTH, LANE_W, DEPTH)) begin : g_bad_params
        $error("std_reg_bank: WIDTH must be a multiple of LANE_W and DEPTH must be >= 2");
    end

    // One extra bit so the bound is representable when DEPTH is a power of two.
    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    logic             accept;
    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] entry_we;
    logic [WIDTH-1:0] stor0;
    logic [WIDTH-1:0] stor1;
    logic             stor0_valid;
    logic             stor1_valid;

    // clear beats a same-cycle write; out-of-range addresses are silently dropped.
    assign accept = write_en && ({1'b0, waddr} < DEPTH_LIM) && !clear;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign entry_we[gi] = accept && (waddr == AW'(gi));

        std_reg_entry #(
            .WIDTH  (WIDTH),
            .LANE_W (LANE_W)
        ) u_entry (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .we    (entry_we[gi]),
            .wmask (wmask),
            .in    (in),
            .q     (entry_q[gi]),
            .valid (entry_valid[gi])
        );
    end

    // Storage read muxes; an address with no matching entry reads as zero/invalid.
    always_comb begin
        stor0       = '0;
        stor1       = '0;
        stor0_valid = 1'b0;
        stor1_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr0 == AW'(i)) begin
                stor0       = entry_q[i];
                stor0_valid = entry_valid[i];
            end
            if (raddr1 == AW'(i)) begin
                stor1       = entry_q[i];
                stor1_valid = entry_valid[i];
            end
        end
    end

`ifdef STD_REG_BANK_BYPASS_EN
    logic [WIDTH-1:0] wmask_bits;

    assign wmask_bits = WIDTH'(expand_mask(MASK_MAX'(wmask), LANE_W));

    // Forward the merged write value when a port reads the entry being written;
    // accept already excludes clear, so a flush never forwards.
    always_comb begin
        out0       = stor0;
        out1       = stor1;
        out0_valid = stor0_valid;
        out1_valid = stor1_valid;
        if (accept && (raddr0 == waddr)) begin
            out0       = (stor0 & ~wmask_bits) | (in & wmask_bits);
            out0_valid = 1'b1;
        end
        if (accept && (raddr1 == waddr)) begin
            out1       = (stor1 & ~wmask_bits) | (in & wmask_bits);
            out1_valid = 1'b1;
        end
    end
`else
    // No forwarding: read ports reflect registered storage only.
    always_comb begin
        out0       = stor0;
        out1       = stor1;
        out0_valid = stor0_valid;
        out1_valid = stor1_valid;
    end
`endif

    // done pulses for exactly the cycle following each accepted write.
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= accept;
        end
    end

endmodule

// File: tb/tb_std_reg_bank.sv
// Self-checking bench for std_reg_bank (DEPTH=3 so out-of-range addresses exist).
module tb_std_reg_bank;

    localparam int W  = 32;
    localparam int LW = 8;
    localparam int D  = 3;
    localparam int NL = W / LW;
    localparam int A  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          write_en;
    logic [A-1:0]  waddr;
    logic [NL-1:0] wmask;
    logic [W-1:0]  in_data;
    logic          clear;
    logic [A-1:0]  raddr0;
    logic [A-1:0]  raddr1;
    logic [W-1:0]  out0;
    logic [W-1:0]  out1;
    logic          out0_valid;
    logic          out1_valid;
    logic          done;

    int checks   = 0;
    int failures = 0;

    // Reference state: what the bank should hold after each edge.
    logic [W-1:0] mdata  [D];
    bit           mvalid [D];
    bit           mdone;

    std_reg_bank #(.WIDTH(W), .LANE_W(LW), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .write_en   (write_en),
        .waddr      (waddr),
        .wmask      (wmask),
        .in         (in_data),
        .clear      (clear),
        .raddr0     (raddr0),
        .raddr1     (raddr1),
        .out0       (out0),
        .out1       (out1),
        .out0_valid (out0_valid),
        .out1_valid (out1_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] merge(input logic [W-1:0] old_v, input logic [W-1:0] new_v,
                                           input logic [NL-1:0] m);
        logic [W-1:0] r;
        r = old_v;
        for (int l = 0; l < NL; l++) begin
            if (m[l]) r[l*LW +: LW] = new_v[l*LW +: LW];
        end
        return r;
    endfunction

    function automatic bit accepted();
        return write_en && (int'(waddr) < D) && !clear;
    endfunction

    function automatic logic [W-1:0] exp_data(input logic [A-1:0] ra);
        logic [W-1:0] v;
        if (int'(ra) >= D) return '0;
        v = mdata[int'(ra)];
`ifdef STD_REG_BANK_BYPASS_EN
        if (accepted() && ra == waddr) v = merge(v, in_data, wmask);
`endif
        return v;
    endfunction

    function automatic bit exp_valid(input logic [A-1:0] ra);
        bit v;
        if (int'(ra) >= D) return 1'b0;
        v = mvalid[int'(ra)];
`ifdef STD_REG_BANK_BYPASS_EN
        if (accepted() && ra == waddr) v = 1'b1;
`endif
        return v;
    endfunction

    // Apply the bank's rules to the reference state for the coming edge.
    task automatic model_edge();
        if (reset || clear) begin
            for (int i = 0; i < D; i++) begin
                mdata[i]  = '0;
                mvalid[i] = 1'b0;
            end
            mdone = 1'b0;
        end else begin
            if (accepted()) begin
                mdata[int'(waddr)]  = merge(mdata[int'(waddr)], in_data, wmask);
                mvalid[int'(waddr)] = 1'b1;
            end
            mdone = accepted();
        end
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        write_en = 0; waddr = 0; wmask = 0; in_data = 0; clear = 0; raddr0 = 0; raddr1 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        advance();
        advance();
        reset = 0;
        for (int c = 0; c < 5; c++) begin
            raddr0 = A'(c % 4);
            raddr1 = A'((c + 1) % 4);
            settle();
            checks++;
            if (out0 !== '0 || out1 !== '0 || out0_valid !== 1'b0 || out1_valid !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got out0=%h out1=%h v0=%b v1=%b done=%b want all zero",
                         c, out0, out1, out0_valid, out1_valid, done);
            end
            advance();
        end
    endtask

    task automatic test_full_write();
        idle_inputs();
        write_en = 1; waddr = 2; in_data = 32'hDEADBEEF; wmask = 4'hF;
        advance();
        write_en = 0; raddr0 = 2; raddr1 = 0;
        settle();
        checks++;
        if (done !== 1'b1 || out0 !== 32'hDEADBEEF || out0_valid !== 1'b1) begin
            failures++;
            $display("FAIL full_write got done=%b out0=%h v0=%b want done=1 out0=deadbeef v0=1",
                     done, out0, out0_valid);
        end
        for (int e = 0; e < 2; e++) begin
            raddr1 = A'(e);
            #1;
            checks++;
            if (out1_valid !== 1'b0 || out1 !== '0) begin
                failures++;
                $display("FAIL other_invalid entry=%0d got out1=%h v1=%b want 0/0", e, out1, out1_valid);
            end
        end
        advance();
        settle();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_one_cycle got done=%b want 0", done);
        end
    endtask

    task automatic test_lane_mask();
        idle_inputs();
        write_en = 1; waddr = 1; in_data = 32'h11223344; wmask = 4'hF;
        advance();
        in_data = 32'hAABBCCDD; wmask = 4'b0101;
        advance();
        write_en = 0; raddr1 = 1;
        settle();
        checks++;
        if (out1 !== 32'h11BB33DD || out1_valid !== 1'b1) begin
            failures++;
            $display("FAIL lane_mask got out1=%h v1=%b want 11bb33dd/1", out1, out1_valid);
        end
        // Empty mask still marks the entry valid.
        write_en = 1; waddr = 0; in_data = 32'hFFFFFFFF; wmask = 4'h0;
        advance();
        write_en = 0; raddr0 = 0;
        settle();
        checks++;
        if (out0 !== '0 || out0_valid !== 1'b1 || done !== 1'b1) begin
            failures++;
            $display("FAIL empty_mask got out0=%h v0=%b done=%b want 0/1/1", out0, out0_valid, done);
        end
        advance();
    endtask

    task automatic test_clear_wins();
        idle_inputs();
        write_en = 1; waddr = 0; in_data = 32'h12345678; wmask = 4'hF; clear = 1;
        advance();
        idle_inputs();
        settle();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL clear_done got done=%b want 0", done);
        end
        for (int e = 0; e < D; e++) begin
            raddr0 = A'(e); raddr1 = A'(e);
            #1;
            checks++;
            if (out0 !== '0 || out1 !== '0 || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
                failures++;
                $display("FAIL clear_state entry=%0d got out0=%h out1=%h v0=%b v1=%b want zero",
                         e, out0, out1, out0_valid, out1_valid);
            end
        end
        advance();
    endtask

    task automatic test_out_of_range_and_back_to_back();
        idle_inputs();
        write_en = 1; waddr = 3; in_data = 32'hCAFEF00D; wmask = 4'hF;
        advance();
        write_en = 0;
        settle();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL oor_done got done=%b want 0", done);
        end
        for (int e = 0; e < 4; e++) begin
            raddr0 = A'(e);
            #1;
            checks++;
            if (out0 !== '0 || out0_valid !== 1'b0) begin
                failures++;
                $display("FAIL oor_state addr=%0d got out0=%h v0=%b want 0/0", e, out0, out0_valid);
            end
        end
        advance();
        for (int e = 0; e < 4; e++) begin
            write_en = (e < 3);
            waddr = A'(e % 3);
            in_data = 32'h100 + 32'(e);
            wmask = 4'hF;
            advance();
            settle();
            checks++;
            if (done !== (e < 3)) begin
                failures++;
                $display("FAIL back_to_back step=%0d got done=%b want %b", e, done, (e < 3));
            end
        end
        write_en = 0;
    endtask

    task automatic test_same_cycle_read();
        idle_inputs();
        clear = 1;
        advance();
        clear = 0;
        write_en = 1; waddr = 0; in_data = 32'h5; wmask = 4'hF; raddr0 = 0;
        settle();
        checks++;
`ifdef STD_REG_BANK_BYPASS_EN
        if (out0 !== 32'h5 || out0_valid !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_bypass got out0=%h v0=%b want 5/1", out0, out0_valid);
        end
`else
        if (out0 !== '0 || out0_valid !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_old got out0=%h v0=%b want 0/0", out0, out0_valid);
        end
`endif
        advance();
        write_en = 0;
        settle();
        checks++;
        if (out0 !== 32'h5 || out0_valid !== 1'b1) begin
            failures++;
            $display("FAIL next_cycle_read got out0=%h v0=%b want 5/1", out0, out0_valid);
        end
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            write_en = ($urandom_range(0, 3) != 0);
            waddr    = A'($urandom_range(0, 3));
            wmask    = NL'($urandom);
            in_data  = $urandom;
            clear    = ($urandom_range(0, 19) == 0);
            raddr0   = A'($urandom_range(0, 3));
            raddr1   = A'($urandom_range(0, 3));
            settle();
            checks++;
            if (out0 !== exp_data(raddr0) || out0_valid !== exp_valid(raddr0) ||
                out1 !== exp_data(raddr1) || out1_valid !== exp_valid(raddr1) || done !== mdone) begin
                failures++;
                $display("FAIL random cyc=%0d ra0=%0d ra1=%0d got %h/%b %h/%b done=%b want %h/%b %h/%b done=%b",
                         c, raddr0, raddr1, out0, out0_valid, out1, out1_valid, done,
                         exp_data(raddr0), exp_valid(raddr0), exp_data(raddr1), exp_valid(raddr1), mdone);
            end
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        for (int i = 0; i < D; i++) begin
            mdata[i] = '0;
            mvalid[i] = 1'b0;
        end
        mdone = 1'b0;
        #1;
        test_reset();
        test_full_write();
        test_lane_mask();
        test_clear_wins();
        test_out_of_range_and_back_to_back();
        test_same_cycle_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
